neg_priority_encoder_4x2: RTL and testbench
===========================================

// Module: neg_priority_encoder_4x2
// PURPOSE
//   Registered 4-to-2 priority encoder for active-low request lines. It is the inverse of
//   the structural 2x4 negative-output, positive-enable decoder.
//   - Synchronises four active-low lines and reports the highest-priority asserted line
//     as a 2-bit code over a valid/ready handshake.
//   - After a report, waits for all lines to release before it can report again.
//   - Sits between decoder-driven select lines (or external buttons) and downstream logic.
// PARAMETERS
//   SYNC_STAGES  2   flops per input line in the synchroniser; legal range 1..4
//   COUNT_W      8   width of the saturating handshake event counter
//   MSB_PRIO     1   1: d_n[3] has highest priority; 0: d_n[0] has highest priority
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high; clears all state immediately
//   en         in   1        positive enable; gates new captures only
//   d_n        in   4        active-low request lines; line i is asserted when d_n[i]=0
//   out_ready  in   1        consumer accepts code this cycle
//   code       out  2        index of the winning line; 2'b00 while reset
//   valid      out  1        code/multi are valid; 0 while reset
//   multi      out  1        more than one line was asserted at capture; 0 while reset
//   busy       out  1        1 in HOLD or RELEASE; 0 while reset
//   evt_count  out  COUNT_W  number of completed handshakes, saturating; 0 while reset
// BEHAVIOUR
//   - Synchroniser: d_n passes through SYNC_STAGES flops, all reset to 4'b1111
//     (no line asserted). s_n is the synchronised value; act = ~s_n.
//   - FSM states: IDLE=0, HOLD=1, RELEASE=2. Reset state is IDLE.
//   - IDLE -> HOLD: when en=1 and act!=0.
//     - Same edge: latch code = priority index of act, multi = (popcount(act)>1), valid=1.
//     - en=0 or act=0: stay in IDLE, outputs unchanged, valid=0.
//   - HOLD: valid=1; code and multi are held stable regardless of en or d_n.
//     - valid & out_ready at an edge: handshake completes.
//     - That edge: valid->0, evt_count+1 (holds at 2^COUNT_W-1), next state RELEASE.
//     - out_ready may be high before valid rises; the handshake then completes on the
//       first edge where valid is high.
//   - RELEASE: valid=0. Move to IDLE on the first edge where act==0. en is ignored.
//     - Goal: one report per press; no re-report of a line that is still held.
//   - Latency: d_n stable from before rising edge N -> valid=1 after edge N+SYNC_STAGES,
//     with en=1 and the FSM in IDLE. Minimum turnaround is 1 cycle in HOLD.
//   - Priority (MSB_PRIO=1): act=4'b0110 -> code=2'd2, multi=1. Mirrored when MSB_PRIO=0.
//   - Request lines that change during HOLD do not affect code. A line that releases and
//     re-asserts within HOLD is not reported.
//   - busy = (state != IDLE).
//   - Asynchronous rst in any state: outputs return to reset values immediately. The
//     pending code is discarded and evt_count is not incremented.
//   - After rst deasserts, the synchroniser refills from 4'b1111. A line held low through
//     reset is reported SYNC_STAGES edges later, as a fresh event.
// TESTING
//   1. For each i in 0..3, d_n=~(1<<i), en=1, out_ready=1 -> code=i, multi=0,
//      valid high 1 cycle, evt_count 0->4 after the sweep.
//   2. d_n=4'b0101, MSB_PRIO=1 -> code=2'd3, multi=1; same stimulus, MSB_PRIO=0 -> code=2'd1.
//   3. en=0, d_n=4'b1110 for 10 cycles -> valid stays 0; raise en -> valid after 1 edge
//      (synchroniser already full).
//   4. d_n=4'b1101, out_ready=0 for 5 cycles, then 1 -> valid/code=2'd1 held 5+ cycles,
//      one handshake. Hold d_n low 8 more cycles -> no second valid. Release, re-press
//      -> second report.
//   5. rst pulse (async, mid-cycle) while in HOLD -> valid, busy, code=0 immediately;
//      evt_count unchanged at 0 from reset.
//   6. COUNT_W=2, 5 handshakes -> evt_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/neg_priority_encoder_4x2_if.sv
// Request/report bus of the active-low 4-to-2 priority encoder.
interface neg_priority_encoder_4x2_if #(
   parameter int unsigned COUNT_W = 8
);
   logic               en;
   logic [3:0]         d_n;
   logic               out_ready;
   logic [1:0]         code;
   logic               valid;
   logic               multi;
   logic               busy;
   logic [COUNT_W-1:0] evt_count;

   // Producer of requests / consumer of reports
   modport master (
      output en, d_n, out_ready,
      input  code, valid, multi, busy, evt_count
   );

   // The encoder itself
   modport slave (
      input  en, d_n, out_ready,
      output code, valid, multi, busy, evt_count
   );
endinterface

// File: rtl/neg_priority_encoder_4x2.sv
// Registered 4-to-2 priority encoder for active-low request lines.
// One report per press: after a handshake it waits for every line to release.
module neg_priority_encoder_4x2 #(
   parameter int unsigned SYNC_STAGES = 2,   // legal range 1..4
   parameter int unsigned COUNT_W     = 8,
   parameter int unsigned MSB_PRIO    = 1
) (
   input logic                      clk,
   input logic                      rst,
   neg_priority_encoder_4x2_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             r_state;
   logic [3:0]         r_sync [SYNC_STAGES];
   logic [1:0]         r_code;
   logic               r_valid;
   logic               r_multi;
   logic               r_busy;
   logic [COUNT_W-1:0] r_cnt;

   logic [3:0]         w_act;
   logic [1:0]         w_code;
   logic               w_multi;

   assign w_act = ~r_sync[SYNC_STAGES-1];

   // Synchroniser chain; resets to "no line asserted"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'hF;
      end else begin
         r_sync[0] <= bus.d_n;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // Priority index of the asserted lines; the last hit in the scan wins
   always_comb begin
      w_code = 2'd0;
      if (MSB_PRIO != 0) begin
         for (int i = 0; i < 4; i++) begin
            if (w_act[i]) w_code = 2'(i);
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (w_act[i]) w_code = 2'(i);
         end
      end
   end

   // More than one line asserted: clearing the lowest set bit leaves something
   assign w_multi = ((w_act & (w_act - 4'd1)) != 4'd0);

   // Capture / handshake / release FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_code  <= 2'd0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.en && (w_act != 4'd0)) begin
                  r_code  <= w_code;
                  r_multi <= w_multi;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               // valid is always high here, so ready alone completes the handshake
               if (bus.out_ready) begin
                  r_valid <= 1'b0;
                  if (r_cnt != {COUNT_W{1'b1}}) r_cnt <= r_cnt + COUNT_W'(1);
                  r_state <= RELEASE;
               end
            end
            RELEASE: begin
               if (w_act == 4'd0) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.code      = r_code;
   assign bus.valid     = r_valid;
   assign bus.multi     = r_multi;
   assign bus.busy      = r_busy;
   assign bus.evt_count = r_cnt;

endmodule

// File: tb/tb_neg_priority_encoder_4x2.sv
// Scoreboard bench: instance A (MSB priority, 8-bit counter) and instance B
// (LSB priority, 2-bit counter) share clock, reset and stimulus.
module tb_neg_priority_encoder_4x2;

   typedef struct packed {
      logic [1:0] code;
      logic       multi;
   } exp_t;

   logic clk;
   logic rst;

   neg_priority_encoder_4x2_if #(.COUNT_W(8)) ifa ();
   neg_priority_encoder_4x2_if #(.COUNT_W(2)) ifb ();

   neg_priority_encoder_4x2 #(.SYNC_STAGES(2), .COUNT_W(8), .MSB_PRIO(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   neg_priority_encoder_4x2 #(.SYNC_STAGES(2), .COUNT_W(2), .MSB_PRIO(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   exp_t qa[$];
   exp_t qb[$];
   int   pushes = 0;
   int   na = 0;
   int   nb = 0;
   int   hs = 0;
   logic pa = 1'b0;
   logic pb = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor A: every rising valid is a new report, compared against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (ifa.valid && !pa) begin
         na++;
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_unexpected_report: got code=%0d, expected no report", ifa.code);
         end else begin
            e = qa.pop_front();
            chk("a_code", int'(ifa.code), int'(e.code));
            chk("a_multi", int'(ifa.multi), int'(e.multi));
         end
      end
      pa = ifa.valid;
   end

   // Monitor B
   always @(negedge clk) begin
      exp_t e;
      if (ifb.valid && !pb) begin
         nb++;
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected_report: got code=%0d, expected no report", ifb.code);
         end else begin
            e = qb.pop_front();
            chk("b_code", int'(ifb.code), int'(e.code));
            chk("b_multi", int'(ifb.multi), int'(e.multi));
         end
      end
      pb = ifb.valid;
   end

   task automatic set_in(input logic en, input logic [3:0] dn, input logic rdy);
      ifa.en = en; ifa.d_n = dn; ifa.out_ready = rdy;
      ifb.en = en; ifb.d_n = dn; ifb.out_ready = rdy;
   endtask

   task automatic expect_rep(input logic [1:0] ca, input logic [1:0] cb, input logic m);
      exp_t ea;
      exp_t eb;
      ea.code = ca; ea.multi = m;
      eb.code = cb; eb.multi = m;
      qa.push_back(ea);
      qb.push_back(eb);
      pushes++;
   endtask

   task automatic wait_valid(input logic want, input string nm);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ifa.valid == want) break;
      end
      chk(nm, int'(ifa.valid), int'(want));
   endtask

   task automatic wait_idle(input string nm);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!ifa.busy) break;
      end
      chk(nm, int'(ifa.busy), 0);
   endtask

   task automatic chk_counts(input string nm);
      chk({nm, "_evt_a"}, int'(ifa.evt_count), hs);
      chk({nm, "_evt_b"}, int'(ifb.evt_count), (hs > 3) ? 3 : hs);
   endtask

   // Full press: assert lines, accept report, release, back to IDLE
   task automatic press(input logic [3:0] dn, input logic [1:0] ca, input logic [1:0] cb,
                        input logic m, input string nm);
      expect_rep(ca, cb, m);
      @(negedge clk);
      set_in(1'b1, dn, 1'b1);
      wait_valid(1'b1, {nm, "_valid"});
      wait_valid(1'b0, {nm, "_ack"});
      hs++;
      chk_counts(nm);
      set_in(1'b1, 4'hF, 1'b1);
      wait_idle({nm, "_idle"});
   endtask

   initial begin
      logic ok;
      rst = 1'b1;
      set_in(1'b0, 4'hF, 1'b0);
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_code", int'(ifa.code), 0);
      chk("rst_valid", int'(ifa.valid), 0);
      chk("rst_multi", int'(ifa.multi), 0);
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_evt", int'(ifa.evt_count), 0);
      rst = 1'b0;

      // Single-line sweep; B's 2-bit counter saturates along the way
      press(4'b1110, 2'd0, 2'd0, 1'b0, "sweep0");
      press(4'b1101, 2'd1, 2'd1, 1'b0, "sweep1");
      press(4'b1011, 2'd2, 2'd2, 1'b0, "sweep2");
      press(4'b0111, 2'd3, 2'd3, 1'b0, "sweep3");

      // Multi-line priority, opposite winners in A and B
      press(4'b0101, 2'd3, 2'd1, 1'b1, "prio0101");
      press(4'b1001, 2'd2, 2'd1, 1'b1, "prio1001");
      press(4'b0000, 2'd3, 2'd0, 1'b1, "prio0000");

      // Enable low: no capture; raising en reports after one edge
      @(negedge clk);
      set_in(1'b0, 4'b1110, 1'b1);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ifa.valid || ifa.busy) ok = 1'b0;
      end
      chk("en_low_no_valid", int'(ok), 1);
      expect_rep(2'd0, 2'd0, 1'b0);
      ifa.en = 1'b1; ifb.en = 1'b1;
      @(negedge clk);
      chk("en_rise_latency", int'(ifa.valid), 1);
      wait_valid(1'b0, "en_ack");
      hs++;
      chk_counts("en");
      set_in(1'b1, 4'hF, 1'b1);
      wait_idle("en_idle");

      // Backpressure: report held stable, one handshake, no re-report while held
      expect_rep(2'd1, 2'd1, 1'b0);
      @(negedge clk);
      set_in(1'b1, 4'b1101, 1'b0);
      wait_valid(1'b1, "bp_valid");
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!ifa.valid || ifa.code != 2'd1 || ifa.evt_count != 8'(hs)) ok = 1'b0;
      end
      chk("bp_hold_stable", int'(ok), 1);
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
      wait_valid(1'b0, "bp_ack");
      hs++;
      chk_counts("bp");
      ok = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (ifa.valid || !ifa.busy) ok = 1'b0;
      end
      chk("bp_no_rereport", int'(ok), 1);
      set_in(1'b1, 4'hF, 1'b1);
      wait_idle("bp_idle");
      press(4'b1101, 2'd1, 2'd1, 1'b0, "bp_repress");

      // Asynchronous reset in HOLD, then the held line reports again as a fresh event
      expect_rep(2'd2, 2'd2, 1'b0);
      @(negedge clk);
      set_in(1'b1, 4'b1011, 1'b0);
      wait_valid(1'b1, "ar_valid");
      #2 rst = 1'b1;
      #1;
      chk("ar_valid_cleared", int'(ifa.valid), 0);
      chk("ar_busy_cleared", int'(ifa.busy), 0);
      chk("ar_code_cleared", int'(ifa.code), 0);
      chk("ar_evt_a", int'(ifa.evt_count), 0);
      chk("ar_evt_b", int'(ifb.evt_count), 0);
      hs = 0;
      @(negedge clk);
      rst = 1'b0;
      expect_rep(2'd2, 2'd2, 1'b0);
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
      wait_valid(1'b1, "ar_fresh_valid");
      wait_valid(1'b0, "ar_fresh_ack");
      hs++;
      chk_counts("ar");
      set_in(1'b1, 4'hF, 1'b1);
      wait_idle("ar_idle");

      repeat (3) @(negedge clk);
      chk("a_report_count", na, pushes);
      chk("b_report_count", nb, pushes);
      chk("a_queue_left", qa.size(), 0);
      chk("b_queue_left", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
